// File: rtl/synth_bus_pkg.sv
// Shared definitions for the synth register bus and the voice allocator.
package synth_bus_pkg;

  // Register offsets inside one voice block
  localparam logic [15:0] REG_GATE       = 16'd0;
  localparam logic [15:0] REG_INCR       = 16'd1;
  localparam logic [15:0] REG_WAVETYPE   = 16'd4;
  localparam logic [15:0] REG_PULSEWIDTH = 16'd5;
  localparam logic [15:0] REG_ATTACK     = 16'd8;
  localparam logic [15:0] REG_DECAY      = 16'd11;
  localparam logic [15:0] REG_SUSTAIN    = 16'd14;
  localparam logic [15:0] REG_RELEASE    = 16'd17;
  localparam logic [15:0] REG_LINEAR     = 16'd20;

  // Storage width of the age field; the allocator saturates below this
  localparam int AGE_MAX_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOOKUP, ST_KILL, ST_INCR0, ST_INCR1, ST_INCR2, ST_GATE
  } alloc_state_t;

  typedef enum logic [1:0] {
    WR_IDLE, WR_SETUP, WR_HOLD
  } write_phase_t;

  typedef struct packed {
    logic                 active;
    logic [6:0]           note;
    logic [AGE_MAX_W-1:0] age;
  } voice_entry_t;

  // Absolute address of a register in voice v
  function automatic logic [15:0] voice_addr(input logic [15:0] base,
                                             input logic [15:0] stride,
                                             input logic [2:0]  v,
                                             input logic [15:0] off);
    return base + (16'(v) * stride) + off;
  endfunction

  // Index of the lowest set bit (0 when none set)
  function automatic logic [2:0] lowest_set(input logic [7:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Index of the maximum age, lowest index winning ties
  function automatic logic [2:0] oldest_voice(input logic [7:0][AGE_MAX_W-1:0] ages);
    logic [2:0]           idx;
    logic [AGE_MAX_W-1:0] best;
    idx  = 3'd0;
    best = ages[0];
    for (int i = 1; i < 8; i++) begin
      if (ages[i] > best) begin
        best = ages[i];
        idx  = 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_byte_writer.sv
// Two-cycle byte write sequencer: SETUP (strobe high) then HOLD (strobe low).
module bus_byte_writer
  import synth_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] addr,
  input  logic [7:0]  data,
  output logic        done,
  output logic [15:0] bus_address,
  output logic [7:0]  bus_data,
  output logic        bus_read_write,
  output logic        bus_clock
);

  write_phase_t phase_r;
  logic [15:0]  addr_r;
  logic [7:0]   data_r;
  logic         rw_r;
  logic         strobe_r;

  // Load a new byte on start, drop the strobe for HOLD, otherwise park the bus at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_r  <= WR_IDLE;
      addr_r   <= 16'd0;
      data_r   <= 8'd0;
      rw_r     <= 1'b0;
      strobe_r <= 1'b0;
    end else if (start) begin
      phase_r  <= WR_SETUP;
      addr_r   <= addr;
      data_r   <= data;
      rw_r     <= 1'b1;
      strobe_r <= 1'b1;
    end else if (phase_r == WR_SETUP) begin
      phase_r  <= WR_HOLD;
      strobe_r <= 1'b0;
    end else begin
      phase_r  <= WR_IDLE;
      addr_r   <= 16'd0;
      data_r   <= 8'd0;
      rw_r     <= 1'b0;
      strobe_r <= 1'b0;
    end
  end

  // HOLD is the last cycle of a byte; the next byte may start at its closing edge
  assign done           = (phase_r == WR_HOLD);
  assign bus_address    = addr_r;
  assign bus_data       = data_r;
  assign bus_read_write = rw_r;
  assign bus_clock      = strobe_r;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic note scheduler: picks a voice per event and programs it over the synth bus.
module voice_allocator
  import synth_bus_pkg::*;
#(
  parameter int          NUM_VOICES   = 4,
  parameter logic [15:0] VOICE_BASE   = 16'h0010,
  parameter logic [15:0] VOICE_STRIDE = 16'h0020,
  parameter int          AGE_W        = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  EvValid,
  output logic                  EvReady,
  input  logic                  EvNoteOn,
  input  logic [6:0]            EvNote,
  input  logic [23:0]           EvIncr,
  output logic [15:0]           BusAddress,
  output logic [7:0]            BusData,
  output logic                  BusReadWrite,
  output logic                  BusClock,
  output logic [NUM_VOICES-1:0] VoiceActive
);

  localparam logic [AGE_MAX_W-1:0] AGE_SAT = AGE_MAX_W'((1 << AGE_W) - 1);

  alloc_state_t state_r, state_s, lookup_next_s;
  logic         ready_r;
  logic         ev_on_r;
  logic [6:0]   ev_note_r;
  logic [23:0]  ev_incr_r;
  logic [2:0]   voice_r, cur_voice_s, lookup_voice_s;
  voice_entry_t voice_tbl_r [NUM_VOICES];

  logic [7:0]                  match_vec_s, free_vec_s;
  logic [7:0][AGE_MAX_W-1:0]   ages_s;
  logic                        start_s, wr_done_s, commit_s;
  logic [15:0]                 wr_off_s, wr_addr_s;
  logic [7:0]                  wr_data_s;

  // Flatten the voice table into match / free / age views for the lookup
  always_comb begin
    match_vec_s = 8'd0;
    free_vec_s  = 8'd0;
    ages_s      = {8 * AGE_MAX_W{1'b0}};
    for (int i = 0; i < NUM_VOICES; i++) begin
      match_vec_s[i] = voice_tbl_r[i].active && (voice_tbl_r[i].note == ev_note_r);
      free_vec_s[i]  = !voice_tbl_r[i].active;
      ages_s[i]      = voice_tbl_r[i].age;
    end
  end

  // Choose the target voice and the first byte state: retrigger, free voice, or steal oldest
  always_comb begin
    lookup_voice_s = 3'd0;
    lookup_next_s  = ST_IDLE;
    if (ev_on_r) begin
      if (|match_vec_s) begin
        lookup_voice_s = lowest_set(match_vec_s);
        lookup_next_s  = ST_KILL;
      end else if (|free_vec_s) begin
        lookup_voice_s = lowest_set(free_vec_s);
        lookup_next_s  = ST_INCR0;
      end else begin
        lookup_voice_s = oldest_voice(ages_s);
        lookup_next_s  = ST_KILL;
      end
    end else begin
      if (|match_vec_s) begin
        lookup_voice_s = lowest_set(match_vec_s);
        lookup_next_s  = ST_GATE;
      end else begin
        lookup_voice_s = 3'd0;
        lookup_next_s  = ST_IDLE;
      end
    end
  end

  // Next state, and the byte to launch whenever a new byte state is entered
  always_comb begin
    state_s     = state_r;
    start_s     = 1'b0;
    cur_voice_s = voice_r;
    wr_off_s    = 16'd0;
    wr_data_s   = 8'd0;
    case (state_r)
      ST_IDLE: begin
        if (EvValid && ready_r) state_s = ST_LOOKUP;
        else                    state_s = ST_IDLE;
      end
      ST_LOOKUP: begin
        state_s     = lookup_next_s;
        cur_voice_s = lookup_voice_s;
        start_s     = (lookup_next_s != ST_IDLE);
      end
      ST_KILL: begin
        if (wr_done_s) begin state_s = ST_INCR0; start_s = 1'b1; end
        else           begin state_s = ST_KILL; end
      end
      ST_INCR0: begin
        if (wr_done_s) begin state_s = ST_INCR1; start_s = 1'b1; end
        else           begin state_s = ST_INCR0; end
      end
      ST_INCR1: begin
        if (wr_done_s) begin state_s = ST_INCR2; start_s = 1'b1; end
        else           begin state_s = ST_INCR1; end
      end
      ST_INCR2: begin
        if (wr_done_s) begin state_s = ST_GATE; start_s = 1'b1; end
        else           begin state_s = ST_INCR2; end
      end
      ST_GATE: begin
        if (wr_done_s) state_s = ST_IDLE;
        else           state_s = ST_GATE;
      end
      default: state_s = ST_IDLE;
    endcase
    case (state_s)
      ST_KILL:  begin wr_off_s = REG_GATE;          wr_data_s = 8'd0;             end
      ST_INCR0: begin wr_off_s = REG_INCR;          wr_data_s = ev_incr_r[7:0];   end
      ST_INCR1: begin wr_off_s = REG_INCR + 16'd1;  wr_data_s = ev_incr_r[15:8];  end
      ST_INCR2: begin wr_off_s = REG_INCR + 16'd2;  wr_data_s = ev_incr_r[23:16]; end
      ST_GATE:  begin wr_off_s = REG_GATE;          wr_data_s = {7'd0, ev_on_r};  end
      default:  begin wr_off_s = 16'd0;             wr_data_s = 8'd0;             end
    endcase
  end

  assign wr_addr_s = voice_addr(VOICE_BASE, VOICE_STRIDE, cur_voice_s, wr_off_s);
  assign commit_s  = (state_s == ST_GATE) && (state_r != ST_GATE);

  // State register, ready flag, event capture and chosen-voice capture
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r   <= ST_IDLE;
      ready_r   <= 1'b0;
      ev_on_r   <= 1'b0;
      ev_note_r <= 7'd0;
      ev_incr_r <= 24'd0;
      voice_r   <= 3'd0;
    end else begin
      state_r <= state_s;
      ready_r <= (state_s == ST_IDLE);
      if (state_r == ST_IDLE && EvValid && ready_r) begin
        ev_on_r   <= EvNoteOn;
        ev_note_r <= EvNote;
        ev_incr_r <= EvIncr;
      end
      if (state_r == ST_LOOKUP) voice_r <= lookup_voice_s;
    end
  end

  // Voice table update on the edge that enters GATE
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        voice_tbl_r[i].active <= 1'b0;
        voice_tbl_r[i].note   <= 7'd0;
        voice_tbl_r[i].age    <= {AGE_MAX_W{1'b0}};
      end
    end else if (commit_s) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (3'(i) == cur_voice_s) begin
          voice_tbl_r[i].active <= ev_on_r;
          if (ev_on_r) begin
            voice_tbl_r[i].note <= ev_note_r;
            voice_tbl_r[i].age  <= {AGE_MAX_W{1'b0}};
          end
        end else if (ev_on_r && voice_tbl_r[i].active && (voice_tbl_r[i].age < AGE_SAT)) begin
          voice_tbl_r[i].age <= voice_tbl_r[i].age + {{(AGE_MAX_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // Gate-open status straight from the table
  always_comb begin
    VoiceActive = {NUM_VOICES{1'b0}};
    for (int i = 0; i < NUM_VOICES; i++) begin
      VoiceActive[i] = voice_tbl_r[i].active;
    end
  end

  assign EvReady = ready_r;

  bus_byte_writer u_writer (
    .clk            (Clock),
    .rst            (Reset),
    .start          (start_s),
    .addr           (wr_addr_s),
    .data           (wr_data_s),
    .done           (wr_done_s),
    .bus_address    (BusAddress),
    .bus_data       (BusData),
    .bus_read_write (BusReadWrite),
    .bus_clock      (BusClock)
  );

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphonic note scheduler that owns the synth register bus as its only master.
- Accepts note-on/note-off events over a valid/ready handshake and assigns each note-on to a free voice; when none is free, it steals the oldest voice.
- Sequences the byte writes that program the voice's Incr register and open or close its Gate.
- Sits between the note source (key scanner/MIDI decoder) and TopLevel's Bus* inputs.

Parameters:
- NUM_VOICES, 4, number of voice register blocks managed (1..8).
- VOICE_BASE, 16'h0010, bus address of voice 0 Gate register.
- VOICE_STRIDE, 16'h0020, address distance between consecutive voice blocks.
- AGE_W, 4, width of each voice's saturating age counter.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- EvValid  in  1  event present.
- EvReady  out  1  allocator can accept an event this cycle.
- EvNoteOn  in  1  1 = note-on, 0 = note-off.
- EvNote  in  7  note identifier.
- EvIncr  in  24  phase increment for note-on; ignored for note-off.
- BusAddress  out  16  register address.
- BusData  out  8  write data; the top level drives the tristate.
- BusReadWrite  out  1  1 = write cycle in progress.
- BusClock  out  1  write strobe.
- VoiceActive  out  NUM_VOICES  per-voice gate-open status.

Behaviour:
- Reset (async): all outputs 0, voice table cleared (inactive, note=0, age=0), FSM to IDLE. Any in-flight write is abandoned; BusClock falls immediately.
- Byte write takes 2 cycles:
  - SETUP: BusAddress/BusData valid, BusReadWrite=1, BusClock=1.
  - HOLD: same address/data, BusClock=0.
  - Consecutive bytes run back to back.
- Outside writes: BusReadWrite=0, BusClock=0, BusAddress=0, BusData=0.
- Addressing: voice v base = VOICE_BASE + v*VOICE_STRIDE. Gate at +0 (1=open, 0=closed). Incr at +1..+3, LSB first.
- EvReady=1 only in IDLE. An event is accepted on an edge where EvValid&&EvReady, and its fields are registered.
- FSM states: IDLE -> LOOKUP (1 cycle) -> optional KILL (Gate=0 byte) -> INCR0 -> INCR1 -> INCR2 -> GATE -> IDLE. Note-off uses LOOKUP -> GATE(0) -> IDLE, or LOOKUP -> IDLE if no match.
- LOOKUP priority for note-on:
  - (1) an active voice already holding EvNote: retrigger that voice with KILL.
  - (2) the lowest-index inactive voice: no KILL.
  - (3) otherwise steal the active voice with the maximum age, lowest index on ties, with KILL.
- Note-on commit, at entry to GATE: chosen voice becomes active, note=EvNote, age=0. Every other active voice gets age+1, saturating at 2^AGE_W-1. Inactive ages are unchanged.
- Note-off: the matching active voice gets a Gate=0 write and becomes inactive at entry to GATE. If several voices match (not reachable via retrigger rule), the lowest index is used.
- Latency, event accepted at edge T:
  - Free-voice note-on: LOOKUP in cycle T, first SETUP at T+1, GATE HOLD at T+8, EvReady=1 at T+9.
  - Stolen or retriggered note-on: EvReady at T+11.
  - Matched note-off: EvReady at T+3.
  - Unmatched note-off: EvReady at T+1.
- VoiceActive reflects the table and updates on the GATE-entry edge.
- EvValid deasserting before acceptance has no effect. No event is queued.

Decomposition:
- Package synth_bus_pkg:
  - register offsets: REG_GATE=0, REG_INCR=1, REG_WAVETYPE=4, REG_PULSEWIDTH=5, REG_ATTACK=8, REG_DECAY=11, REG_SUSTAIN=14, REG_RELEASE=17, REG_LINEAR=20;
  - allocator FSM state enum;
  - voice-entry struct {active, note, age}.
- Sub-module bus_byte_writer: start/addr/data in, 2-cycle SETUP/HOLD sequencing, done pulse, drives Bus* outputs; the allocator FSM drives it.

Test Plan:
- Reset, then note-on note=60 incr=24'h0FFFFF -> writes 0x11=FF, 0x12=FF, 0x13=0F, 0x10=01. VoiceActive=4'b0001. EvReady returns 9 cycles after acceptance.
- Four note-ons 60, 62, 64, 65, then note-on 67 incr=24'h00FFFF -> voice 0 (age 3) stolen: 0x10=00, 0x11=FF, 0x12=FF, 0x13=00, 0x10=01. VoiceActive stays 4'b1111.
- Note-on 60 on voice 0, then note-off 60 -> single write 0x10=00. VoiceActive=0. Note-off 61 afterwards -> no bus activity, EvReady back after 1 cycle.
- Note-on 60 twice with different incr -> second event retriggers voice 0 with a KILL byte. Voice 1 is never written.
- Reset asserted during the INCR1 SETUP cycle -> BusClock, BusReadWrite and VoiceActive go to 0 asynchronously. After release, the next note-on uses voice 0.
- Bus timing check: every write shows BusClock high for exactly 1 cycle, with BusAddress/BusData stable from SETUP through HOLD.
